// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS datapath types and constants. This includes the
//               register-file state enum, architectural register indices and
//               default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_AT   = 5'd1;
  localparam logic [4:0] REG_V0   = 5'd2;
  localparam logic [4:0] REG_A0   = 5'd4;
  localparam logic [4:0] REG_T0   = 5'd8;
  localparam logic [4:0] REG_S0   = 5'd16;
  localparam logic [4:0] REG_GP   = 5'd28;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_FP   = 5'd30;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

`default_nettype wire

// File: rtl/regfile_param_if.sv
// ============================================================================
// Module      : regfile_param_if
// Description : Write/read/clear bus of the register file. With the
//               REGFILE_DBG_EN macro defined, the bus adds debug read and
//               write-count signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_param_if #(
  parameter int DATA_W = mips_pkg::RF_DATA_W,
  parameter int ADDR_W = mips_pkg::RF_ADDR_W
);

  logic              write_ena;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_addr1;
  logic [ADDR_W-1:0] read_addr2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              clear_req;
  logic              ready;
`ifdef REGFILE_DBG_EN
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [31:0]       wr_count;

  modport master (
    output write_ena, write_addr, write_data, read_addr1, read_addr2,
           clear_req, dbg_addr,
    input  read_data1, read_data2, ready, dbg_data, wr_count
  );
  modport slave (
    input  write_ena, write_addr, write_data, read_addr1, read_addr2,
           clear_req, dbg_addr,
    output read_data1, read_data2, ready, dbg_data, wr_count
  );
`else
  modport master (
    output write_ena, write_addr, write_data, read_addr1, read_addr2,
           clear_req,
    input  read_data1, read_data2, ready
  );
  modport slave (
    input  write_ena, write_addr, write_data, read_addr1, read_addr2,
           clear_req,
    output read_data1, read_data2, ready
  );
`endif

endinterface

`default_nettype wire

// File: rtl/regfile_param_rd_port.sv
// ============================================================================
// Module      : regfile_rd_port
// Description : One read port of the register file. It applies the sweep
//               blanking, the zero-entry force and the write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_byp_en,
  input  logic [ADDR_W-1:0] i_byp_addr,
  input  logic [DATA_W-1:0] i_byp_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_zero_hit;
  logic w_byp_hit;

  assign w_zero_hit = (ZERO_REG != 0) && (i_addr == '0);
  assign w_byp_hit  = i_byp_en && (i_byp_addr == i_addr);

  always_comb begin
    o_data = '0;
    if (i_run && !w_zero_hit) begin
      o_data = w_byp_hit ? i_byp_data : i_mem_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_param.sv
// ============================================================================
// Module      : regfile_param
// Description : Parametrised 2-read/1-write register file with a clear sweep,
//               write bypass and optional hardwired zero entry. The
//               REGFILE_DBG_EN macro adds a debug read port and a write counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_param
  import mips_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_param_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_idx = '1;

  rf_state_e         r_state;
  rf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_run;
  logic w_wr_acc;

  assign w_run = (r_state == RF_RUN);

  // Accepted write. The same term drives the bypass, so a write that is
  // dropped (clear, sweep or zero entry) is never forwarded either.
  assign w_wr_acc = w_run && bus.write_ena && !bus.clear_req &&
                    !((ZERO_REG != 0) && (bus.write_addr == '0));

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      RF_CLEAR: begin
        if (bus.clear_req) begin
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
          if (r_clr_idx == c_last_idx) begin
            w_state_nxt = RF_RUN;
          end
        end
      end
      RF_RUN: begin
        if (bus.clear_req) begin
          w_state_nxt   = RF_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = RF_CLEAR;
        w_clr_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RF_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Storage has no reset so it maps onto RAM; the sweep does the zeroing.
  always_ff @(posedge clk) begin
    if (r_state == RF_CLEAR) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_acc) begin
      r_mem[bus.write_addr] <= bus.write_data;
    end
  end

  assign bus.ready = w_run;

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd_port1 (
    .i_run      (w_run),
    .i_addr     (bus.read_addr1),
    .i_mem_data (r_mem[bus.read_addr1]),
    .i_byp_en   (w_wr_acc),
    .i_byp_addr (bus.write_addr),
    .i_byp_data (bus.write_data),
    .o_data     (bus.read_data1)
  );

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd_port2 (
    .i_run      (w_run),
    .i_addr     (bus.read_addr2),
    .i_mem_data (r_mem[bus.read_addr2]),
    .i_byp_en   (w_wr_acc),
    .i_byp_addr (bus.write_addr),
    .i_byp_data (bus.write_data),
    .o_data     (bus.read_data2)
  );

`ifdef REGFILE_DBG_EN
  logic [31:0] r_wr_count;

  regfile_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_rd_port_dbg (
    .i_run      (w_run),
    .i_addr     (bus.dbg_addr),
    .i_mem_data (r_mem[bus.dbg_addr]),
    .i_byp_en   (1'b0),
    .i_byp_addr ('0),
    .i_byp_data ('0),
    .o_data     (bus.dbg_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_count <= '0;
    end else if (bus.clear_req) begin
      r_wr_count <= '0;
    end else if (w_wr_acc && (r_wr_count != '1)) begin
      r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign bus.wr_count = r_wr_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_param.sv
// ============================================================================
// Module      : tb_regfile_param
// Description : Self-checking bench for regfile_param. It runs ZERO_REG=1 and
//               ZERO_REG=0 instances side by side against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_param;
  import mips_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          we  = 1'b0;
  logic          clr = 1'b0;
  logic [AW-1:0] wa  = '0;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic [AW-1:0] da  = '0;
  logic [DW-1:0] wd  = '0;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();

  assign bus1.write_ena  = we;
  assign bus1.write_addr = wa;
  assign bus1.write_data = wd;
  assign bus1.read_addr1 = ra1;
  assign bus1.read_addr2 = ra2;
  assign bus1.clear_req  = clr;
  assign bus0.write_ena  = we;
  assign bus0.write_addr = wa;
  assign bus0.write_data = wd;
  assign bus0.read_addr1 = ra1;
  assign bus0.read_addr2 = ra2;
  assign bus0.clear_req  = clr;
`ifdef REGFILE_DBG_EN
  assign bus1.dbg_addr = da;
  assign bus0.dbg_addr = da;
`endif

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  // Reference model: index 1 is the ZERO_REG=1 instance, index 0 the other.
  // A clear is modelled as an instant wipe followed by DEPTH blind cycles.
  logic [DW-1:0] m_mem [0:1][0:DEPTH-1];
  logic [31:0]   m_wcnt [0:1];
  bit            m_ready = 1'b0;
  int            m_left  = DEPTH;

  initial begin
    for (int z = 0; z < 2; z++) begin
      m_wcnt[z] = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[z][i] = '0;
    end
  end

  always @(posedge clk) begin
    if (!rst || clr) begin
      m_ready = 1'b0;
      m_left  = DEPTH;
      for (int z = 0; z < 2; z++) begin
        m_wcnt[z] = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[z][i] = '0;
      end
    end else if (!m_ready) begin
      m_left = m_left - 1;
      if (m_left == 0) m_ready = 1'b1;
    end else if (we) begin
      for (int z = 0; z < 2; z++) begin
        if (!(z == 1 && wa == '0)) begin
          m_mem[z][wa] = wd;
          if (m_wcnt[z] != 32'hFFFF_FFFF) m_wcnt[z] = m_wcnt[z] + 32'd1;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_rd(input int z, input logic [AW-1:0] ra);
    if (!rst || !m_ready) return '0;
    if (z == 1 && ra == '0) return '0;
    if (we && !clr && wa == ra && !(z == 1 && wa == '0)) return wd;
    return m_mem[z][ra];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("ready1", 32'(bus1.ready), 32'(rst && m_ready));
    chk("ready0", 32'(bus0.ready), 32'(rst && m_ready));
    chk("zr1_rd1", bus1.read_data1, exp_rd(1, ra1));
    chk("zr1_rd2", bus1.read_data2, exp_rd(1, ra2));
    chk("zr0_rd1", bus0.read_data1, exp_rd(0, ra1));
    chk("zr0_rd2", bus0.read_data2, exp_rd(0, ra2));
`ifdef REGFILE_DBG_EN
    chk("zr1_dbg", bus1.dbg_data, (!rst || !m_ready || da == '0) ? '0 : m_mem[1][da]);
    chk("zr0_dbg", bus0.dbg_data, (!rst || !m_ready) ? '0 : m_mem[0][da]);
    chk("zr1_wcnt", bus1.wr_count, rst ? m_wcnt[1] : '0);
    chk("zr0_wcnt", bus0.wr_count, rst ? m_wcnt[0] : '0);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until ready rises; read port 1 must stay 0 meanwhile.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      step();
      n++;
      if (!bus1.ready) chk("sweep_rd", bus1.read_data1, 32'h0);
    end while (!bus1.ready && n < 100);
  endtask

  initial begin
    int n;
    ra1 = AW'(7);
    step(); step(); step();
    rst = 1'b1;
    wait_ready(n);
    chk("sweep_len_init", n, 32);

    we = 1'b1; wa = AW'(9); wd = 32'hDEADBEEF;
    step();
    we = 1'b0; ra1 = AW'(9); ra2 = AW'(9);
    @(negedge clk);
    chk("wr9_rd1", bus1.read_data1, 32'hDEADBEEF);
    chk("wr9_rd2", bus1.read_data2, 32'hDEADBEEF);
    chk("wr9_zr0_rd1", bus0.read_data1, 32'hDEADBEEF);

    step();
    we = 1'b1; wa = AW'(17); wd = 32'h12345678; ra2 = AW'(17);
    @(negedge clk);
    chk("bypass_rd2", bus1.read_data2, 32'h12345678);

    step();
    we = 1'b1; wa = AW'(0); wd = 32'hFFFFFFFF; ra1 = AW'(0);
    @(negedge clk);
    chk("zero_during_zr1", bus1.read_data1, 32'h0);
    chk("zero_during_zr0", bus0.read_data1, 32'hFFFFFFFF);
    step();
    we = 1'b0;
    @(negedge clk);
    chk("zero_after_zr1", bus1.read_data1, 32'h0);
    chk("zero_after_zr0", bus0.read_data1, 32'hFFFFFFFF);

    step();
    clr = 1'b1; we = 1'b1; wa = AW'(3); wd = 32'hAA; ra1 = AW'(3);
    step();
    clr = 1'b0; we = 1'b0;
    wait_ready(n);
    chk("sweep_len_clear", n, 32);
    @(negedge clk);
    chk("clear_drop_zr1", bus1.read_data1, 32'h0);
    chk("clear_drop_zr0", bus0.read_data1, 32'h0);

    step();
    for (int i = 1; i <= 3; i++) begin
      we = 1'b1; wa = AW'(i); wd = 32'($urandom);
      step();
    end
    we = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
`ifdef REGFILE_DBG_EN
    chk("wcnt_after_clear", bus1.wr_count, 32'h0);
`endif
    repeat (10) step();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    wait_ready(n);
    chk("sweep_len_rst", n, 32);

    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 399) != 0);
      clr = ($urandom_range(0, 149) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(0, DEPTH - 1));
      wd  = 32'($urandom);
      ra1 = $urandom_range(0, 1) ? wa : AW'($urandom_range(0, DEPTH - 1));
      ra2 = $urandom_range(0, 1) ? wa : AW'($urandom_range(0, DEPTH - 1));
      da  = AW'($urandom_range(0, DEPTH - 1));
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
